// File: rtl/fp_align_pipe_pkg.sv
// Shared definitions for the FP operand-alignment pipeline.
//   - Default field widths for single precision (E8/M23) with 3 GRS bits.
//   - Helpers for the aligned mantissa width and the exponent bias.
//   - Operand-select enum used by the magnitude compare stage.
package fp_align_pipe_pkg;

   localparam int unsigned E_WIDTH_DEF = 8;
   localparam int unsigned M_WIDTH_DEF = 23;
   localparam int unsigned GRS_DEF     = 3;

   // Aligned mantissa width: hidden bit + stored mantissa + GRS bits.
   function automatic int unsigned aligned_width(input int unsigned m_width,
                                                 input int unsigned grs);
      return m_width + 1 + grs;
   endfunction

   function automatic int unsigned exp_bias(input int unsigned e_width);
      return (1 << (e_width - 1)) - 1;
   endfunction

   typedef enum logic {
      SEL_A = 1'b0,
      SEL_B = 1'b1
   } big_sel_e;

endpackage

// File: rtl/fp_sticky_shifter.sv
// Combinational right shifter with sticky collection.
// Ports:
//   data_i  [W-1:0]     value to shift
//   amt_i   [SH_W-1:0]  right-shift amount (unsigned)
//   data_o  [W-1:0]     shifted value; OR of every bit shifted out lands in bit 0
module fp_sticky_shifter #(
   parameter int unsigned W    = 27,
   parameter int unsigned SH_W = 8
) (
   input  logic [W-1:0]    data_i,
   input  logic [SH_W-1:0] amt_i,
   output logic [W-1:0]    data_o
);

   logic [W-1:0] lost_mask;
   logic         sticky;

   always_comb begin
      data_o    = '0;
      lost_mask = '0;
      sticky    = 1'b0;
      if (32'(amt_i) >= W) begin
         // Everything is shifted out; only the sticky survives.
         data_o = {{(W-1){1'b0}}, |data_i};
      end else begin
         lost_mask = ~({W{1'b1}} << amt_i);
         sticky    = |(data_i & lost_mask);
         data_o    = (data_i >> amt_i) | {{(W-1){1'b0}}, sticky};
      end
   end

endmodule

// File: rtl/fp_align_pipe.sv
// Two-stage operand-alignment pipeline for the FP add/sub datapath.
// Stage 1 orders the operands by magnitude and registers the big/small
// mantissas (hidden bit restored), the exponent difference, the effective
// operation and the result sign. Stage 2 aligns the small mantissa with a
// sticky-collecting right shift and registers the outputs.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready              input handshake
//   sign_a/exp_a/man_a             operand A fields
//   sign_b/exp_b/man_b             operand B fields
//   sub_op                         1 = A-B, 0 = A+B
//   out_valid/out_ready            output handshake
//   out_sign, out_exp              result sign and larger effective exponent
//   out_man_big, out_man_sml       aligned mantissas {hidden, man, GRS}
//   out_eff_sub                    adder must subtract
module fp_align_pipe
   import fp_align_pipe_pkg::*;
#(
   parameter  int unsigned E_WIDTH = E_WIDTH_DEF,
   parameter  int unsigned M_WIDTH = M_WIDTH_DEF,
   parameter  int unsigned GRS     = GRS_DEF,
   localparam int unsigned MW      = aligned_width(M_WIDTH, GRS)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               sign_a,
   input  logic [E_WIDTH-1:0] exp_a,
   input  logic [M_WIDTH-1:0] man_a,
   input  logic               sign_b,
   input  logic [E_WIDTH-1:0] exp_b,
   input  logic [M_WIDTH-1:0] man_b,
   input  logic               sub_op,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_sign,
   output logic [E_WIDTH-1:0] out_exp,
   output logic [MW-1:0]      out_man_big,
   output logic [MW-1:0]      out_man_sml,
   output logic               out_eff_sub
);

   // Stage-1 registers
   logic               s1_valid_q;
   logic               s1_sign_q,   s1_sign_d;
   logic               s1_eff_q,    s1_eff_d;
   logic [E_WIDTH-1:0] s1_exp_q,    s1_exp_d;
   logic [E_WIDTH-1:0] s1_diff_q,   s1_diff_d;
   logic [MW-1:0]      s1_big_q,    s1_big_d;
   logic [MW-1:0]      s1_sml_q,    s1_sml_d;

   // Stage-2 (output) registers
   logic               s2_valid_q;
   logic               s2_sign_q;
   logic               s2_eff_q;
   logic [E_WIDTH-1:0] s2_exp_q;
   logic [MW-1:0]      s2_big_q;
   logic [MW-1:0]      s2_sml_q;

   logic               s1_adv;
   logic [MW-1:0]      sml_aligned;

   // Stage-1 compare signals
   logic               hid_a, hid_b;
   logic [E_WIDTH-1:0] eexp_a, eexp_b;
   logic [M_WIDTH:0]   sig_a, sig_b;
   logic               eff_sign_b;
   big_sel_e           sel;

   assign s1_adv   = !s2_valid_q || out_ready;
   assign in_ready = !s1_valid_q || s1_adv;

   always_comb begin
      hid_a      = |exp_a;
      hid_b      = |exp_b;
      eexp_a     = hid_a ? exp_a : E_WIDTH'(1);
      eexp_b     = hid_b ? exp_b : E_WIDTH'(1);
      sig_a      = {hid_a, man_a};
      sig_b      = {hid_b, man_b};
      eff_sign_b = sign_b ^ sub_op;
      s1_eff_d   = sign_a ^ eff_sign_b;

      // Tie-break on the significand including the hidden bit so that a
      // denormal never outranks a normal sharing effective exponent 1.
      if ((eexp_a > eexp_b) || ((eexp_a == eexp_b) && (sig_a >= sig_b)))
         sel = SEL_A;
      else
         sel = SEL_B;

      if (sel == SEL_A) begin
         s1_sign_d = sign_a;
         s1_exp_d  = eexp_a;
         s1_diff_d = eexp_a - eexp_b;
         s1_big_d  = {sig_a, {GRS{1'b0}}};
         s1_sml_d  = {sig_b, {GRS{1'b0}}};
      end else begin
         s1_sign_d = eff_sign_b;
         s1_exp_d  = eexp_b;
         s1_diff_d = eexp_b - eexp_a;
         s1_big_d  = {sig_b, {GRS{1'b0}}};
         s1_sml_d  = {sig_a, {GRS{1'b0}}};
      end

      // Exact cancellation yields +0.
      if (s1_eff_d && (eexp_a == eexp_b) && (sig_a == sig_b))
         s1_sign_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_sign_q  <= 1'b0;
         s1_eff_q   <= 1'b0;
         s1_exp_q   <= '0;
         s1_diff_q  <= '0;
         s1_big_q   <= '0;
         s1_sml_q   <= '0;
      end else if (in_ready) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_sign_q <= s1_sign_d;
            s1_eff_q  <= s1_eff_d;
            s1_exp_q  <= s1_exp_d;
            s1_diff_q <= s1_diff_d;
            s1_big_q  <= s1_big_d;
            s1_sml_q  <= s1_sml_d;
         end
      end
   end

   fp_sticky_shifter #(
      .W    (MW),
      .SH_W (E_WIDTH)
   ) u_shift (
      .data_i (s1_sml_q),
      .amt_i  (s1_diff_q),
      .data_o (sml_aligned)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_q <= 1'b0;
         s2_sign_q  <= 1'b0;
         s2_eff_q   <= 1'b0;
         s2_exp_q   <= '0;
         s2_big_q   <= '0;
         s2_sml_q   <= '0;
      end else if (s1_adv) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_sign_q <= s1_sign_q;
            s2_eff_q  <= s1_eff_q;
            s2_exp_q  <= s1_exp_q;
            s2_big_q  <= s1_big_q;
            s2_sml_q  <= sml_aligned;
         end
      end
   end

   assign out_valid   = s2_valid_q;
   assign out_sign    = s2_sign_q;
   assign out_eff_sub = s2_eff_q;
   assign out_exp     = s2_exp_q;
   assign out_man_big = s2_big_q;
   assign out_man_sml = s2_sml_q;

endmodule
